sdram_burst_sched: RTL and testbench



---
 rtl/sdram_burst_sched.sv | 147 ++++++++++++++
 tb/tb_sdram_burst_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sched.sv
// rtl/sdram_burst_sched.sv - picks the next SDRAM burst (refresh, write or read) from FIFO levels
// and a refresh timer, and tracks the circular write/read pointers into SDRAM.
module sdram_burst_sched #(
  parameter int ADDR_W       = 24,
  parameter int BURST_LEN    = 256,
  parameter int FIFO_DEPTH   = 512,
  parameter int WFIFO_THRESH = 256,
  parameter int REF_INTERVAL = 780
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  input  logic [9:0]        w_data_count,
  input  logic [9:0]        r_data_count,
  output logic              cmd_req,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic [ADDR_W:0]   sd_level,
  output logic              busy,
  output logic              ref_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN} state_t;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_WR   = 2'b01;
  localparam logic [1:0] T_RD   = 2'b10;
  localparam logic [1:0] T_REF  = 2'b11;

  localparam int REF_W = $clog2(REF_INTERVAL);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REF_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] BURST_PTR = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W:0]   BURST_LVL = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   WR_LIMIT  = (ADDR_W+1)'((1 << ADDR_W) - BURST_LEN);
  localparam logic [9:0]        W_THRESH  = 10'(WFIFO_THRESH);
  localparam logic [9:0]        R_LIMIT   = 10'(FIFO_DEPTH - BURST_LEN);

  state_t             state, state_d;
  logic [1:0]         type_q, type_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W:0]    level;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pend;
  logic               last_wr, last_wr_d;
  logic               ref_wrap, wr_ok, rd_ok, complete, ref_ack;

  assign ref_wrap = (ref_cnt == REF_LAST);
  assign wr_ok    = (w_data_count >= W_THRESH) && (level <= WR_LIMIT);
  assign rd_ok    = (level >= BURST_LVL) && (r_data_count <= R_LIMIT);

  always_comb begin
    state_d   = state;
    type_d    = type_q;
    addr_d    = addr_q;
    last_wr_d = last_wr;
    complete  = 1'b0;
    ref_ack   = 1'b0;
    case (state)
      S_IDLE: begin
        type_d = T_NONE;
        if (ref_pend) begin
          type_d  = T_REF;
          addr_d  = '0;
          state_d = S_REQ;
        end else if (wr_ok && (!rd_ok || !last_wr)) begin
          type_d    = T_WR;
          addr_d    = wr_ptr;
          last_wr_d = 1'b1;
          state_d   = S_REQ;
        end else if (rd_ok) begin
          type_d    = T_RD;
          addr_d    = rd_ptr;
          last_wr_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (cmd_ack) begin
          ref_ack = (type_q == T_REF);
          // an arbiter may finish a short command in the same cycle it accepts it
          if (cmd_done) begin
            complete = 1'b1;
            type_d   = T_NONE;
            state_d  = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cmd_done) begin
          complete = 1'b1;
          type_d   = T_NONE;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      state       <= S_IDLE;
      type_q      <= T_NONE;
      addr_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      last_wr     <= 1'b0;
    end else begin
      state   <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      last_wr <= last_wr_d;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // a new interval outranks the ack of the previous refresh
      if (ref_wrap) ref_pend <= 1'b1;
      else if (ref_ack) ref_pend <= 1'b0;
      if (ref_wrap && ref_pend && !ref_ack) ref_overrun <= 1'b1;
      if (complete) begin
        case (type_q)
          T_WR: begin
            wr_ptr <= wr_ptr + BURST_PTR;
            level  <= level + BURST_LVL;
          end
          T_RD: begin
            rd_ptr <= rd_ptr + BURST_PTR;
            level  <= level - BURST_LVL;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_req  = (state == S_REQ);
  assign busy     = (state != S_IDLE);
  assign cmd_type = type_q;
  assign cmd_addr = addr_q;
  assign sd_level = level;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb/tb_sdram_burst_sched.sv - scoreboard bench for sdram_burst_sched with a small arbiter model
module tb_sdram_burst_sched;
  localparam int AW   = 12;
  localparam int BL   = 256;
  localparam int NREF = 200;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    w_cnt, r_cnt;
  logic          cmd_req, cmd_ack, cmd_done, busy, ref_overrun;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   sd_level;

  sdram_burst_sched #(.ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(512),
                      .WFIFO_THRESH(256), .REF_INTERVAL(NREF)) dut (
    .sysclk_100M(clk), .rst(rst), .w_data_count(w_cnt), .r_data_count(r_cnt),
    .cmd_req(cmd_req), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done), .sd_level(sd_level),
    .busy(busy), .ref_overrun(ref_overrun));

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] lvl;
    logic [9:0]  nw;
    logic [9:0]  nr;
    bit          same;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int p_wr = 0, p_rd = 0, p_lvl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [9:0] nw, input logic [9:0] nr, input bit same);
    exp_t e;
    e.typ = 2'b01; e.addr = p_wr; e.nw = nw; e.nr = nr; e.same = same;
    p_wr  = (p_wr + BL) % DEPTH;
    p_lvl = p_lvl + BL;
    e.lvl = p_lvl;
    q.push_back(e);
  endtask

  task automatic push_rd(input logic [9:0] nw, input logic [9:0] nr, input bit same);
    exp_t e;
    e.typ = 2'b10; e.addr = p_rd; e.nw = nw; e.nr = nr; e.same = same;
    p_rd  = (p_rd + BL) % DEPTH;
    p_lvl = p_lvl - BL;
    e.lvl = p_lvl;
    q.push_back(e);
  endtask

  task automatic serve_ref();
    check("ref_addr", 32'(cmd_addr), 0);
    cmd_ack = 1'b1;
    @(negedge clk) cmd_ack = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk) cmd_done = 1'b0;
  endtask

  task automatic wait_req(input bit serve_refs, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_req) begin
        if (serve_refs && cmd_type == 2'b11) serve_ref();
        else begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) check("req_timeout", 0, 1);
  endtask

  task automatic do_burst(input exp_t e);
    bit ok;
    wait_req(1'b1, ok);
    if (!ok) return;
    check("cmd_type", 32'(cmd_type), 32'(e.typ));
    check("cmd_addr", 32'(cmd_addr), e.addr);
    if (e.same) begin
      cmd_ack = 1'b1; cmd_done = 1'b1; w_cnt = e.nw; r_cnt = e.nr;
      @(negedge clk) begin cmd_ack = 1'b0; cmd_done = 1'b0; end
    end else begin
      cmd_ack = 1'b1;
      @(negedge clk) cmd_ack = 1'b0;
      check("req_drop", 32'(cmd_req), 0);
      check("busy_run", 32'(busy), 1);
      @(negedge clk);
      w_cnt = e.nw; r_cnt = e.nr; cmd_done = 1'b1;
      @(negedge clk) cmd_done = 1'b0;
    end
    check("sd_level", 32'(sd_level), e.lvl);
    check("type_none", 32'(cmd_type), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic run_queue();
    while (q.size() > 0) do_burst(q.pop_front());
  endtask

  task automatic idle_watch(input int ncyc, input string tag);
    int bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (cmd_req) begin
        if (cmd_type == 2'b11) serve_ref();
        else begin
          bad++;
          break;
        end
      end
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cnt;
    rst = 1'b1; w_cnt = '0; r_cnt = '0; cmd_ack = 1'b0; cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(cmd_req), 0);
    check("rst_type", 32'(cmd_type), 0);
    check("rst_addr", 32'(cmd_addr), 0);
    check("rst_level", 32'(sd_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(ref_overrun), 0);
    rst = 1'b0;

    // first refresh lands REF_INTERVAL+1 cycles after reset release
    cnt = 0;
    while (!cmd_req && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("first_ref_cycle", cnt, NREF + 1);
    check("first_ref_type", 32'(cmd_type), 3);
    serve_ref();

    // refresh becomes pending while a write sits in RUN
    w_cnt = 10'd300; r_cnt = 10'd300;
    wait_req(1'b1, ok);
    check("pri_wr_type", 32'(cmd_type), 1);
    check("pri_wr_addr", 32'(cmd_addr), 0);
    cmd_ack = 1'b1;
    @(negedge clk) cmd_ack = 1'b0;
    for (int i = 0; i < 1000 && (cyc % NREF) != 1; i++) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk) cmd_done = 1'b0;
    check("pri_wr_level", 32'(sd_level), 256);
    p_wr = 256; p_lvl = 256;
    wait_req(1'b0, ok);
    check("pri_ref_first", 32'(cmd_type), 3);
    check("ovr_before", 32'(ref_overrun), 0);
    repeat (2 * NREF) @(negedge clk);
    check("ovr_after", 32'(ref_overrun), 1);
    serve_ref();

    // second write, then alternating read/write, then same-cycle ack+done
    push_wr(10'd300, 10'd0, 1'b0);
    push_rd(10'd300, 10'd0, 1'b0);
    push_wr(10'd300, 10'd0, 1'b0);
    push_rd(10'd300, 10'd0, 1'b0);
    push_wr(10'd300, 10'd300, 1'b0);
    push_wr(10'd300, 10'd300, 1'b1);
    while (p_lvl < DEPTH) push_wr(10'd300, 10'd300, 1'b0);
    run_queue();
    check("full_level", 32'(sd_level), DEPTH);

    idle_watch(100, "full_blocks_wr");
    r_cnt = 10'd257;
    idle_watch(100, "r257_blocks_rd");
    push_rd(10'd0, 10'd300, 1'b0);
    r_cnt = 10'd256;
    run_queue();

    // reset while a write is in RUN, then a late done
    w_cnt = 10'd300;
    wait_req(1'b1, ok);
    check("rr_type", 32'(cmd_type), 1);
    check("rr_addr", 32'(cmd_addr), p_wr);
    cmd_ack = 1'b1; w_cnt = '0;
    @(negedge clk) cmd_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rr_req", 32'(cmd_req), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_level", 32'(sd_level), 0);
    check("rr_ovr", 32'(ref_overrun), 0);
    cmd_done = 1'b1;
    @(negedge clk) cmd_done = 1'b0;
    check("late_done_busy", 32'(busy), 0);
    check("late_done_level", 32'(sd_level), 0);
    @(negedge clk);
    check("late_done_req", 32'(cmd_req), 0);

    p_wr = 0; p_rd = 0; p_lvl = 0;
    w_cnt = 10'd300; r_cnt = 10'd300;
    push_wr(10'd0, 10'd300, 1'b0);
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
